chunk_deskew: RTL and testbench

Downstream alignment stage for the chunked pipelined arithmetic units such as the subtractor and adder. Those units emit result chunk i one enable-cycle after chunk i-1, so a WIDTH-bit result arrives skewed across NCHUNK cycles. This block delays each chunk so that all chunks of one result leave together as a single aligned word, with its valid bit and its final borrow/carry flag. It sits between the arithmetic core and any consumer that needs whole words.

---
 rtl/pipelined_math_pkg.sv | 27 ++
 rtl/delay_line.sv | 44 ++++
 rtl/chunk_deskew.sv | 88 ++++++++
 tb/tb_chunk_deskew.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_math_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_math_pkg
//  Description : Shared helpers for the chunked pipelined arithmetic family
//                (adder, subtractor, chunk_deskew). Provides the integer
//                ceil-division and min functions and the chunk_count helper
//                used to size the per-chunk pipelines.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_math_pkg;

    // Integer ceiling division; b is assumed positive.
    function automatic int ceil_division(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Number of chunks a WIDTH-bit word splits into at CHUNK bits per chunk.
    function automatic int chunk_count(input int width, input int chunk);
        return ceil_division(width, chunk);
    endfunction

endpackage : pipelined_math_pkg
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line
//  Description : Fixed-depth register chain. Every stage advances only when
//                en is high; a synchronous active-low reset clears all stages
//                regardless of en.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous reset, active low, overrides en
//                en    - advance enable
//                d     - W-bit input
//                q     - W-bit output, d delayed by DEPTH enabled cycles
//  Parameters  : DEPTH (>= 1) number of stages, W data width
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule : delay_line
`default_nettype wire

// File: rtl/chunk_deskew.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_deskew
//  Description : Realigns a chunk-skewed result from a chunked pipelined
//                arithmetic unit. Chunk i arrives i en-cycles after chunk 0
//                and is delayed by NCHUNK-i stages so all chunks leave
//                together, NCHUNK en-cycles after chunk 0 entered.
//  Ports       : clk       - clock, rising edge
//                rst_n     - synchronous reset, active low, overrides en
//                en        - pipeline advance; all registers hold when low
//                in_valid  - chunk 0 of a new word is on in[CHUNK-1:0]
//                in        - skewed WIDTH-bit result
//                in_flag   - borrow/carry, arrives with the top chunk
//                out       - aligned word (don't-care while out_valid low)
//                out_valid - out/flag hold a complete word
//                flag      - aligned borrow/carry
//  Macro       : CHUNK_DESKEW_FLAG_EN - when defined the flag is pipelined;
//                otherwise in_flag is ignored and flag is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_deskew
    import pipelined_math_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             in_flag,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             flag
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);

    // Chunk i is delayed by NCHUNK-i stages; the top chunk may be narrower.
    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
        localparam int LO = i * CHUNK;
        localparam int WI = min(CHUNK, WIDTH - LO);

        delay_line #(
            .DEPTH (NCHUNK - i),
            .W     (WI)
        ) u_chunk_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (in[LO +: WI]),
            .q     (out[LO +: WI])
        );
    end

    // Valid travels with chunk 0, so it sees the full NCHUNK stages.
    delay_line #(
        .DEPTH (NCHUNK),
        .W     (1)
    ) u_valid_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (in_valid),
        .q     (out_valid)
    );

`ifdef CHUNK_DESKEW_FLAG_EN
    // The flag arrives with the top chunk, which has a single stage left.
    delay_line #(
        .DEPTH (1),
        .W     (1)
    ) u_flag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (in_flag),
        .q     (flag)
    );
`else
    logic unused_in_flag;
    assign unused_in_flag = in_flag;
    assign flag           = 1'b0;
`endif

endmodule : chunk_deskew
`default_nettype wire

// File: tb/tb_chunk_deskew.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chunk_deskew
//  Description : Directed self-checking bench for chunk_deskew. Three
//                instances: WIDTH=8/CHUNK=2, ragged WIDTH=7/CHUNK=3 and the
//                single-stage WIDTH=4/CHUNK=8 case. Inputs change and outputs
//                are sampled 1 time unit after the rising edge. Cycle k means
//                the clock period after the k-th edge following reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_deskew;

`ifdef CHUNK_DESKEW_FLAG_EN
    localparam bit FLAG_ON = 1'b1;
`else
    localparam bit FLAG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;

    // WIDTH=8, CHUNK=2
    logic       a_v, a_f, a_ov, a_of;
    logic [7:0] a_in, a_out;
    // WIDTH=7, CHUNK=3
    logic       r_v, r_f, r_ov, r_of;
    logic [6:0] r_in, r_out;
    // WIDTH=4, CHUNK=8
    logic       d_v, d_f, d_ov, d_of;
    logic [3:0] d_in, d_out;

    int n_vec = 0;
    int n_err = 0;

    chunk_deskew #(.WIDTH(8), .CHUNK(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(a_v), .in(a_in),
        .in_flag(a_f), .out(a_out), .out_valid(a_ov), .flag(a_of)
    );

    chunk_deskew #(.WIDTH(7), .CHUNK(3)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(r_v), .in(r_in),
        .in_flag(r_f), .out(r_out), .out_valid(r_ov), .flag(r_of)
    );

    chunk_deskew #(.WIDTH(4), .CHUNK(8)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(d_v), .in(d_in),
        .in_flag(d_f), .out(d_out), .out_valid(d_ov), .flag(d_of)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_v = 0; a_f = 0; a_in = '0;
        r_v = 0; r_f = 0; r_in = '0;
        d_v = 0; d_f = 0; d_in = '0;
    endtask

    // One reset edge, then release; returns at the start of cycle 0.
    task automatic do_reset();
        idle_inputs();
        en    = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Reset asserted with en low must still clear from the first edge.
        idle_inputs();
        en    = 1'b0;
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({a_out, a_of, a_ov} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_a: got out=%h flag=%b valid=%b, want 0/0/0", a_out, a_of, a_ov);
        end
        n_vec++;
        if ({r_out, r_of, r_ov} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_r: got out=%h flag=%b valid=%b, want 0/0/0", r_out, r_of, r_ov);
        end
        n_vec++;
        if ({d_out, d_of, d_ov} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_d: got out=%h flag=%b valid=%b, want 0/0/0", d_out, d_of, d_ov);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        // 0xA5 = chunks 01,01,10,10 presented at cycles 0..3.
        logic [7:0] vin [8] = '{8'h01, 8'h04, 8'h20, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            a_in = vin[k]; a_v = (k == 0); a_f = (k == 3);
            tick();
            n_vec++;
            if (a_ov !== ((k + 1) == 4)) begin
                n_err++;
                $display("FAIL single_valid c%0d: got %b, want %b", k + 1, a_ov, (k + 1) == 4);
            end
            if ((k + 1) == 4) begin
                n_vec++;
                if (a_out !== 8'hA5 || a_of !== FLAG_ON) begin
                    n_err++;
                    $display("FAIL single_word: got out=%h flag=%b, want A5/%b", a_out, a_of, FLAG_ON);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // Words 12,34,56 started at cycles 0,1,2, interleaved chunk by chunk.
        logic [7:0] vin [9] = '{8'h02, 8'h00, 8'h16, 8'h34, 8'h10, 8'h40, 8'h00, 8'h00, 8'h00};
        logic [7:0] wexp [3] = '{8'h12, 8'h34, 8'h56};
        logic       fexp [3] = '{1'b1, 1'b0, 1'b1};
        int nvalid = 0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            a_in = vin[k]; a_v = (k < 3); a_f = (k == 3) || (k == 5);
            tick();
            if (a_ov === 1'b1) nvalid++;
            n_vec++;
            if (a_ov !== ((k + 1) >= 4 && (k + 1) <= 6)) begin
                n_err++;
                $display("FAIL b2b_valid c%0d: got %b", k + 1, a_ov);
            end
            if ((k + 1) >= 4 && (k + 1) <= 6) begin
                n_vec++;
                if (a_out !== wexp[k-3] || a_of !== (fexp[k-3] & FLAG_ON)) begin
                    n_err++;
                    $display("FAIL b2b_word c%0d: got out=%h flag=%b, want %h/%b",
                             k + 1, a_out, a_of, wexp[k-3], fexp[k-3] & FLAG_ON);
                end
            end
        end
        n_vec++;
        if (nvalid != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d valid cycles, want 3", nvalid);
        end
    endtask

    task automatic test_stall();
        // en low on cycles 2,3; garbage driven there must be ignored.
        logic [7:0] vin [8] = '{8'h01, 8'h04, 8'hFF, 8'hFF, 8'h20, 8'h80, 8'h00, 8'h00};
        logic       ven [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            en   = ven[k];
            a_in = vin[k];
            a_v  = (k == 0) || !ven[k];
            a_f  = (k == 5) || !ven[k];
            tick();
            n_vec++;
            if ((k + 1) == 6) begin
                if (a_ov !== 1'b1 || a_out !== 8'hA5 || a_of !== FLAG_ON) begin
                    n_err++;
                    $display("FAIL stall_word: got out=%h flag=%b valid=%b, want A5/%b/1",
                             a_out, a_of, a_ov, FLAG_ON);
                end
            end else if ((k + 1) <= 5) begin
                if (a_ov !== 1'b0 || a_out !== 8'h00 || a_of !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_hold c%0d: got out=%h flag=%b valid=%b, want 00/0/0",
                             k + 1, a_out, a_of, a_ov);
                end
            end else if (a_ov !== 1'b0) begin
                n_err++;
                $display("FAIL stall_tail c%0d: got valid=%b, want 0", k + 1, a_ov);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [7:0] vin [9] = '{8'h01, 8'h04, 8'h20, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            a_in  = vin[k]; a_v = (k == 0); a_f = (k == 3);
            rst_n = (k != 2);
            tick();
            if ((k + 1) == 3) begin
                n_vec++;
                if (a_ov !== 1'b0 || a_out !== 8'h00 || a_of !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_clear: got out=%h flag=%b valid=%b, want 00/0/0",
                             a_out, a_of, a_ov);
                end
            end else if ((k + 1) > 3) begin
                n_vec++;
                if (a_ov !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_valid c%0d: got %b, want 0", k + 1, a_ov);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ragged();
        // 0x5B = chunks 011, 011, 1 at cycles 0..2.
        logic [6:0] vin [5] = '{7'h03, 7'h18, 7'h40, 7'h00, 7'h00};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            r_in = vin[k]; r_v = (k == 0); r_f = (k == 2);
            tick();
            n_vec++;
            if (r_ov !== ((k + 1) == 3)) begin
                n_err++;
                $display("FAIL ragged_valid c%0d: got %b", k + 1, r_ov);
            end
            if ((k + 1) == 3) begin
                n_vec++;
                if (r_out !== 7'h5B || r_of !== FLAG_ON) begin
                    n_err++;
                    $display("FAIL ragged_word: got out=%h flag=%b, want 5B/%b", r_out, r_of, FLAG_ON);
                end
            end
        end
    endtask

    task automatic test_degenerate();
        logic [3:0] vin [4] = '{4'h9, 4'h6, 4'h0, 4'h0};
        logic       vf  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       vv  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d_in = vin[k]; d_f = vf[k]; d_v = vv[k];
            tick();
            n_vec++;
            if (d_ov !== vv[k] || d_of !== (vf[k] & FLAG_ON) || (vv[k] && d_out !== vin[k])) begin
                n_err++;
                $display("FAIL degen c%0d: got out=%h flag=%b valid=%b, want %h/%b/%b",
                         k + 1, d_out, d_of, d_ov, vin[k], vf[k] & FLAG_ON, vv[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_ragged();
        test_degenerate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_chunk_deskew
`default_nettype wire
